rtc_time_controller: RTL and testbench

//  Controls the real-time-clock chain (seconds, minutes, hours) and owns its three counters.
//  - RUN mode: counts on a 1 Hz enable.
//  - SET modes: a MODE/INC button FSM sequences time setting, one field at a time.
//  - Sits between the 1 Hz tick divider / debounced buttons and the 7-seg display driver.

---
 rtl/rtc_time_controller.sv | 171 +++++++++++++++++
 tb/tb_rtc_time_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_controller.sv
`default_nettype none
// ============================================================================
// Module   : rtc_time_controller
// Purpose  : Real-time-clock controller. Owns the hour/minute/second counters.
//            RUN mode counts on a 1 Hz enable. A MODE/INC button FSM steps
//            through hour, minute and second setting, and returns to RUN on
//            an idle timeout.
// Optional : RTC_ALARM_EN adds an hour:minute alarm compare.
// Ports    : clk_i          system clock, rising edge
//            rst_i          synchronous active-high reset
//            tick_i         1 Hz enable, one clk cycle wide
//            mode_i         debounced MODE pulse
//            inc_i          debounced INC pulse
//            alarm_hour_i   alarm hour   (RTC_ALARM_EN only)
//            alarm_min_i    alarm minute (RTC_ALARM_EN only)
//            alarm_o        one-cycle alarm pulse (RTC_ALARM_EN only)
//            hour_o         hours 0..HOUR_MAX
//            min_o          minutes 0..59
//            sec_o          seconds 0..59
//            sel_o          0 = RUN, 1 = hour, 2 = min, 3 = sec being set
//            day_pulse_o    one-cycle pulse on the end-of-day rollover
// Revision : 1.0 - initial release
// ============================================================================
module rtc_time_controller #(
   parameter int HOUR_MAX    = 23,
   parameter int SET_TIMEOUT = 30,
   parameter int TO_W        = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            tick_i,
   input  logic            mode_i,
   input  logic            inc_i,
`ifdef RTC_ALARM_EN
   input  logic [4:0]      alarm_hour_i,
   input  logic [5:0]      alarm_min_i,
   output logic            alarm_o,
`endif
   output logic [4:0]      hour_o,
   output logic [5:0]      min_o,
   output logic [5:0]      sec_o,
   output logic [1:0]      sel_o,
   output logic            day_pulse_o
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_SET_H = 2'd1;
   localparam logic [1:0] ST_SET_M = 2'd2;
   localparam logic [1:0] ST_SET_S = 2'd3;

   localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);
   localparam logic [5:0] MS_LAST   = 6'd59;
   // Timeout fires on the TICK that would bring the counter to SET_TIMEOUT,
   // so compare against SET_TIMEOUT-1 before incrementing.
   localparam logic [TO_W-1:0] TO_LAST =
      (SET_TIMEOUT > 0) ? TO_W'(SET_TIMEOUT - 1) : '0;

   logic [1:0]      state_q, state_d;
   logic [4:0]      hour_q,  hour_d;
   logic [5:0]      min_q,   min_d;
   logic [5:0]      sec_q,   sec_d;
   logic [TO_W-1:0] to_q,    to_d;
   logic            day_q,   day_d;
`ifdef RTC_ALARM_EN
   logic            alarm_q, alarm_d;
`endif

   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      to_d    = to_q;
      day_d   = 1'b0;

      case (state_q)
         ST_RUN: begin
            to_d = '0;
            // A TICK coinciding with MODE is still counted before leaving RUN.
            if (tick_i) begin
               if (sec_q == MS_LAST) begin
                  sec_d = '0;
                  if (min_q == MS_LAST) begin
                     min_d = '0;
                     if (hour_q == HOUR_LAST) begin
                        hour_d = '0;
                        day_d  = 1'b1;
                     end else begin
                        hour_d = hour_q + 5'd1;
                     end
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            if (mode_i) begin
               state_d = ST_SET_H;
            end
         end
         default: begin
            // SET states: time frozen, MODE beats INC, INC beats TICK.
            if (mode_i) begin
               state_d = (state_q == ST_SET_S) ? ST_RUN : state_q + 2'd1;
               to_d    = '0;
            end else if (inc_i) begin
               to_d = '0;
               case (state_q)
                  ST_SET_H: hour_d = (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
                  ST_SET_M: min_d  = (min_q  == MS_LAST)   ? 6'd0 : min_q  + 6'd1;
                  default:  sec_d  = (sec_q  == MS_LAST)   ? 6'd0 : sec_q  + 6'd1;
               endcase
            end else if (tick_i && (SET_TIMEOUT != 0)) begin
               if (to_q == TO_LAST) begin
                  state_d = ST_RUN;
                  to_d    = '0;
               end else begin
                  to_d = to_q + TO_W'(1);
               end
            end
         end
      endcase
   end

`ifdef RTC_ALARM_EN
   // Only a counting tick in RUN can raise the alarm; edits never do.
   always_comb begin
      alarm_d = (state_q == ST_RUN) && tick_i && (sec_d == 6'd0) &&
                (min_d == alarm_min_i) && (hour_d == alarm_hour_i);
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         hour_q  <= '0;
         min_q   <= '0;
         sec_q   <= '0;
         to_q    <= '0;
         day_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         to_q    <= to_d;
         day_q   <= day_d;
      end
   end

`ifdef RTC_ALARM_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alarm_q <= 1'b0;
      end else begin
         alarm_q <= alarm_d;
      end
   end

   assign alarm_o = alarm_q;
`endif

   assign hour_o      = hour_q;
   assign min_o       = min_q;
   assign sec_o       = sec_q;
   assign sel_o       = state_q;
   assign day_pulse_o = day_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_time_controller
// Purpose  : Self-checking bench for rtc_time_controller: a short table of
//            directed vectors, hand-written corner sequences, then random
//            button/tick traffic compared against a seconds-of-day model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_time_controller;

   localparam int HMAX    = 23;
   localparam int TO      = 30;
   localparam int DAYSEC  = (HMAX + 1) * 3600;

   logic       clk = 1'b0;
   logic       rst, tick, mode, inc;
   logic [4:0] hour;
   logic [5:0] min, sec;
   logic [1:0] sel;
   logic       day;
`ifdef RTC_ALARM_EN
   logic [4:0] alarm_hour = 5'd7;
   logic [5:0] alarm_min  = 6'd30;
   logic       alarm;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: time kept as seconds since midnight.
   int m_t, m_sel, m_to;
   bit m_day;
`ifdef RTC_ALARM_EN
   bit m_alarm;
`endif

   typedef struct {
      bit t, md, in;
      int h, m, s, sl;
      bit dy;
   } vec_t;
   vec_t vecs[12];

   rtc_time_controller #(.HOUR_MAX(HMAX), .SET_TIMEOUT(TO), .TO_W(6)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .tick_i       (tick),
      .mode_i       (mode),
      .inc_i        (inc),
`ifdef RTC_ALARM_EN
      .alarm_hour_i (alarm_hour),
      .alarm_min_i  (alarm_min),
      .alarm_o      (alarm),
`endif
      .hour_o       (hour),
      .min_o        (min),
      .sec_o        (sec),
      .sel_o        (sel),
      .day_pulse_o  (day)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_step(bit r, bit t, bit md, bit in);
      int h, mi, s;
      m_day = 0;
`ifdef RTC_ALARM_EN
      m_alarm = 0;
`endif
      if (r) begin
         m_t = 0; m_sel = 0; m_to = 0;
         return;
      end
      if (m_sel == 0) begin
         if (t) begin
            m_t = (m_t + 1) % DAYSEC;
            if (m_t == 0) m_day = 1;
`ifdef RTC_ALARM_EN
            if (m_t == alarm_hour * 3600 + alarm_min * 60) m_alarm = 1;
`endif
         end
         if (md) begin m_sel = 1; m_to = 0; end
      end else if (md) begin
         m_sel = (m_sel + 1) % 4;
         m_to  = 0;
      end else if (in) begin
         h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
         if (m_sel == 1) h  = (h + 1) % (HMAX + 1);
         if (m_sel == 2) mi = (mi + 1) % 60;
         if (m_sel == 3) s  = (s + 1) % 60;
         m_t  = h * 3600 + mi * 60 + s;
         m_to = 0;
      end else if (t && TO != 0) begin
         m_to++;
         if (m_to == TO) begin m_sel = 0; m_to = 0; end
      end
   endfunction

   task automatic apply(bit r, bit t, bit md, bit in);
      rst = r; tick = t; mode = md; inc = in;
      @(posedge clk);
      #1;
      rst = 0; tick = 0; mode = 0; inc = 0;
   endtask

   // One cycle through DUT and model, then compare all outputs.
   task automatic cyc(bit r, bit t, bit md, bit in);
      apply(r, t, md, in);
      model_step(r, t, md, in);
      chk("hour", 32'(hour), 32'(m_t / 3600));
      chk("min",  32'(min),  32'((m_t / 60) % 60));
      chk("sec",  32'(sec),  32'(m_t % 60));
      chk("sel",  32'(sel),  32'(m_sel));
      chk("day",  32'(day),  32'(m_day));
`ifdef RTC_ALARM_EN
      chk("alarm", 32'(alarm), 32'(m_alarm));
`endif
   endtask

   // Walk the fields up to h:m:s from RUN, ending back in RUN.
   task automatic set_time(int h, int m, int s);
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 32 && (m_t / 3600) != h; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 60 && ((m_t / 60) % 60) != m; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 60 && (m_t % 60) != s; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
   endtask

   initial begin
      int day_seen;
      rst = 1; tick = 0; mode = 0; inc = 0;

      vecs[0]  = '{1,0,0, 0,0,1, 0, 0};   // tick counts
      vecs[1]  = '{0,0,1, 0,0,1, 0, 0};   // INC ignored in RUN
      vecs[2]  = '{1,1,0, 0,0,2, 1, 0};   // MODE+TICK in RUN: tick applied
      vecs[3]  = '{0,0,1, 1,0,2, 1, 0};   // INC hour
      vecs[4]  = '{1,0,0, 1,0,2, 1, 0};   // frozen
      vecs[5]  = '{0,1,1, 1,0,2, 2, 0};   // MODE beats INC
      vecs[6]  = '{0,0,1, 1,1,2, 2, 0};   // INC minute
      vecs[7]  = '{0,1,0, 1,1,2, 3, 0};
      vecs[8]  = '{0,0,1, 1,1,3, 3, 0};   // INC second
      vecs[9]  = '{1,1,0, 1,1,3, 0, 0};   // MODE+TICK in SET_S: tick dropped
      vecs[10] = '{1,0,0, 1,1,4, 0, 0};
      vecs[11] = '{0,0,0, 1,1,4, 0, 0};

      // Reset state
      apply(1, 1, 1, 1);
      chk("rst_hour", 32'(hour), 0);
      chk("rst_min",  32'(min),  0);
      chk("rst_sec",  32'(sec),  0);
      chk("rst_sel",  32'(sel),  0);
      chk("rst_day",  32'(day),  0);

      for (int i = 0; i < 12; i++) begin
         apply(0, vecs[i].t, vecs[i].md, vecs[i].in);
         chk($sformatf("vec%0d_hour", i), 32'(hour), 32'(vecs[i].h));
         chk($sformatf("vec%0d_min",  i), 32'(min),  32'(vecs[i].m));
         chk($sformatf("vec%0d_sec",  i), 32'(sec),  32'(vecs[i].s));
         chk($sformatf("vec%0d_sel",  i), 32'(sel),  32'(vecs[i].sl));
         chk($sformatf("vec%0d_day",  i), 32'(day),  32'(vecs[i].dy));
      end

      // 61 ticks from reset
      cyc(1, 0, 0, 0);
      day_seen = 0;
      for (int k = 0; k < 61; k++) begin
         cyc(0, 1, 0, 0);
         if (day) day_seen = 1;
      end
      chk("t1_sec", 32'(sec), 1);
      chk("t1_min", 32'(min), 1);
      chk("t1_hour", 32'(hour), 0);
      chk("t1_day_never", 32'(day_seen), 0);

      // Hour wrap by INC, frozen counting below the timeout
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 25; k++) cyc(0, 0, 0, 1);
      chk("t2_hour", 32'(hour), 1);
      for (int k = 0; k < 29; k++) cyc(0, 1, 0, 0);
      chk("t2_sec", 32'(sec), 1);
      chk("t2_min", 32'(min), 1);
      chk("t2_sel", 32'(sel), 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);

      // End-of-day rollover
      set_time(23, 59, 59);
      cyc(0, 1, 0, 0);
      chk("t3_day", 32'(day), 1);
      chk("t3_hms", {hour, min, sec}, 0);
      cyc(0, 0, 0, 0);
      chk("t3_day_off", 32'(day), 0);

      // Timeout in SET_M
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 29; k++) cyc(0, 1, 0, 0);
      chk("t4_sel_29", 32'(sel), 2);
      cyc(0, 1, 0, 0);
      chk("t4_sel_30", 32'(sel), 0);
      cyc(0, 1, 0, 0);
      chk("t4_sec", 32'(sec), 1);

      // Timeout expiry coinciding with MODE: MODE wins
      cyc(0, 0, 1, 0);
      for (int k = 0; k < 29; k++) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      chk("t4b_sel", 32'(sel), 2);

      // MODE+INC in SET_H, then reset mid-SET
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      chk("t5_pre_sel", 32'(sel), 1);
      cyc(0, 0, 1, 1);
      chk("t5_sel", 32'(sel), 2);
      chk("t5_hour", 32'(hour), 0);
      cyc(1, 1, 0, 1);
      chk("t5_rst", {hour, min, sec, sel, day}, 0);

`ifdef RTC_ALARM_EN
      set_time(7, 29, 59);
      cyc(0, 1, 0, 0);
      chk("t6_alarm", 32'(alarm), 1);
      cyc(0, 0, 0, 0);
      chk("t6_alarm_off", 32'(alarm), 0);
      cyc(1, 0, 0, 0);
      set_time(7, 30, 0);
      chk("t6_no_alarm", 32'(alarm), 0);
`endif

      // Random traffic against the model
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 4000; k++) begin
         cyc(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
